// File: rtl/reorder_buffer.sv
// In-order retirement buffer sitting after rename: allocates tags, tracks completion,
// retires the head in program order and hands the old physical rd back to rename.
module reorder_buffer #(
  parameter int unsigned NUM_REG      = 32,
  parameter int unsigned NUM_REG_LOG2 = $clog2(NUM_REG),
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TAG_W        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_valid,
  input  logic [NUM_REG_LOG2-1:0] alloc_rd,
  input  logic [NUM_REG_LOG2:0]   alloc_prd_old,
  input  logic [NUM_REG_LOG2:0]   alloc_prd_new,
  output logic [TAG_W-1:0]        alloc_tag,
  output logic                    full,
  output logic                    empty,
  input  logic                    complete_valid,
  input  logic [TAG_W-1:0]        complete_tag,
  input  logic                    commit_ready,
  output logic                    commit_free,
  output logic [NUM_REG_LOG2:0]   prd_free,
  output logic [NUM_REG_LOG2:0]   commit_prd
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        done_q;
  logic [NUM_REG_LOG2-1:0] rd_q      [DEPTH];
  logic [NUM_REG_LOG2:0]   prd_old_q [DEPTH];
  logic [NUM_REG_LOG2:0]   prd_new_q [DEPTH];
  logic [TAG_W-1:0]        head_q;
  logic [TAG_W-1:0]        tail_q;
  logic [TAG_W:0]          count_q;
  logic [TAG_W:0]          count_d;

  logic alloc;
  logic pop;
  logic head_ok;
  logic head_rd_zero;
  logic complete_hit;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign alloc_tag = tail_q;

  assign alloc        = alloc_valid && !full;
  assign head_ok      = valid_q[head_q] && done_q[head_q];
  assign head_rd_zero = (rd_q[head_q] == '0);

  // A completion aimed at the slot being allocated this cycle loses to the allocation.
  assign complete_hit = complete_valid && valid_q[complete_tag] &&
                        !(alloc && (complete_tag == tail_q));

  // rd==0 entries free nothing, so they never wait on rename.
  assign pop         = head_ok && (head_rd_zero || commit_ready) && !flush;
  assign commit_free = head_ok && !head_rd_zero && !flush;
  assign prd_free    = prd_old_q[head_q];
  assign commit_prd  = prd_new_q[head_q];

  always_comb begin
    count_d = count_q;
    unique case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (complete_hit) begin
        done_q[complete_tag] <= 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (!rst && !flush && alloc) begin
      rd_q[tail_q]      <= alloc_rd;
      prd_old_q[tail_q] <= alloc_prd_old;
      prd_new_q[tail_q] <= alloc_prd_new;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int RL2   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             alloc_valid;
  logic [RL2-1:0]   alloc_rd;
  logic [RL2:0]     alloc_prd_old;
  logic [RL2:0]     alloc_prd_new;
  logic [TAG_W-1:0] alloc_tag;
  logic             full;
  logic             empty;
  logic             complete_valid;
  logic [TAG_W-1:0] complete_tag;
  logic             commit_ready;
  logic             commit_free;
  logic [RL2:0]     prd_free;
  logic [RL2:0]     commit_prd;

  reorder_buffer #(
    .NUM_REG(32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_rd      (alloc_rd),
    .alloc_prd_old (alloc_prd_old),
    .alloc_prd_new (alloc_prd_new),
    .alloc_tag     (alloc_tag),
    .full          (full),
    .empty         (empty),
    .complete_valid(complete_valid),
    .complete_tag  (complete_tag),
    .commit_ready  (commit_ready),
    .commit_free   (commit_free),
    .prd_free      (prd_free),
    .commit_prd    (commit_prd)
  );

  always #5 clk = ~clk;

  // Model: the in-flight instructions in program order, oldest first.
  typedef struct {
    int tag;
    int rd;
    int old_p;
    int new_p;
    bit done;
  } ent_t;

  ent_t q[$];
  int   tail_m;
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; check outputs, advance the model, cross one clock edge.
  task automatic cycle();
    bit   h_ok;
    bit   full_m;
    bit   pop_m;
    ent_t e;
    #1;
    full_m = (q.size() == DEPTH);
    h_ok   = 1'b0;
    if (q.size() > 0) h_ok = q[0].done;
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(full_m));
    chk("alloc_tag", 32'(alloc_tag), 32'(tail_m));
    chk("commit_free", 32'(commit_free), 32'(h_ok && q[0].rd != 0 && !flush));
    if (h_ok) begin
      chk("prd_free", 32'(prd_free), 32'(q[0].old_p));
      chk("commit_prd", 32'(commit_prd), 32'(q[0].new_p));
    end
    pop_m = h_ok && (q[0].rd == 0 || commit_ready) && !flush;
    if (rst || flush) begin
      q.delete();
      tail_m = 0;
    end else begin
      if (complete_valid) begin
        foreach (q[i]) if (q[i].tag == int'(complete_tag)) q[i].done = 1'b1;
      end
      if (pop_m) void'(q.pop_front());
      if (alloc_valid && !full_m) begin
        e.tag   = tail_m;
        e.rd    = int'(alloc_rd);
        e.old_p = int'(alloc_prd_old);
        e.new_p = int'(alloc_prd_new);
        e.done  = 1'b0;
        q.push_back(e);
        tail_m = (tail_m + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst            = 1'b0;
    flush          = 1'b0;
    alloc_valid    = 1'b0;
    complete_valid = 1'b0;
  endtask

  task automatic set_alloc(input int rd, input int old_p, input int new_p);
    alloc_valid   = 1'b1;
    alloc_rd      = RL2'(rd);
    alloc_prd_old = (RL2+1)'(old_p);
    alloc_prd_new = (RL2+1)'(new_p);
  endtask

  task automatic set_complete(input int tag);
    complete_valid = 1'b1;
    complete_tag   = TAG_W'(tag);
  endtask

  task automatic rnd_inputs();
    alloc_valid = ($urandom % 3) != 0;
    alloc_rd    = (($urandom % 4) == 0) ? '0 : RL2'($urandom_range(1, 31));
    alloc_prd_old = (RL2+1)'($urandom % 64);
    alloc_prd_new = (RL2+1)'($urandom % 64);
    complete_valid = ($urandom % 2) == 1;
    if (q.size() > 0 && ($urandom % 4) != 0)
      complete_tag = TAG_W'(q[$urandom % q.size()].tag);
    else
      complete_tag = TAG_W'($urandom % DEPTH);
    commit_ready = ($urandom % 4) != 0;
    flush        = ($urandom % 60) == 0;
    rst          = ($urandom % 250) == 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tail_m = 0;
    rst = 1'b1;
    flush = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd = '0;
    alloc_prd_old = '0;
    alloc_prd_new = '0;
    complete_valid = 1'b0;
    complete_tag = '0;
    commit_ready = 1'b1;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_commit_free", 32'(commit_free), 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);

    // Single op.
    set_alloc(5, 5, 32);
    cycle();
    idle();
    set_complete(0);
    cycle();
    idle();
    #1;
    chk("single_commit_free", 32'(commit_free), 32'd1);
    chk("single_prd_free", 32'(prd_free), 32'd5);
    chk("single_commit_prd", 32'(commit_prd), 32'd32);
    cycle();
    cycle();

    // Out-of-order completion, in-order retire.
    for (int i = 0; i < 3; i++) begin
      set_alloc(i + 1, i + 10, i + 40);
      cycle();
    end
    idle();
    set_complete(3);
    cycle();
    set_complete(2);
    cycle();
    set_complete(1);
    cycle();
    idle();
    repeat (4) cycle();

    // Backpressure on a done head.
    set_alloc(7, 17, 50);
    cycle();
    idle();
    commit_ready = 1'b0;
    set_complete(4);
    cycle();
    idle();
    repeat (3) cycle();
    commit_ready = 1'b1;
    cycle();
    cycle();

    // Reset mid-operation, then fill to full, refused 17th, retire 4 and reuse tags 0..3.
    set_alloc(3, 3, 33);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(((i % 2) == 0) ? 0 : i + 1, i, i + 32);
      cycle();
    end
    set_alloc(9, 9, 9);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_complete(i);
      cycle();
    end
    idle();
    repeat (2) cycle();
    for (int i = 0; i < 4; i++) begin
      set_alloc(i + 20, i + 1, i + 60);
      cycle();
    end
    idle();

    // Flush with a same-cycle allocation.
    rst = 1'b1;
    cycle();
    idle();
    commit_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_alloc(i + 1, i + 2, i + 34);
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      set_complete(i);
      cycle();
    end
    idle();
    flush = 1'b1;
    set_alloc(4, 4, 44);
    set_complete(3);
    cycle();
    idle();
    #1;
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("flush_commit_free", 32'(commit_free), 32'd0);
    commit_ready = 1'b1;
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rnd_inputs();
      cycle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
